// File: rtl/str_mc_hb_deci.sv
// -----------------------------------------------------------------------------
// str_mc_hb_deci
//   Multi-channel, time-multiplexed half-band FIR decimate-by-2 stage.
//   NCH channel-interleaved streams share one folded-symmetric sequential MAC.
//   Each channel keeps its own delay line and decimation phase. Every second
//   sample of a channel triggers an accumulation over the centre tap and NP
//   symmetric odd tap pairs. The even off-centre taps are zero and are skipped.
//   A runtime bypass passes samples straight through. m_axis_tuser carries the
//   channel index. m_axis_tlast marks the last channel of every LAST-th frame.
//
// Ports
//   clk            : clock
//   rst_n          : synchronous active-low reset
//   deci_en        : 1 = filter and decimate, 0 = bypass (sampled at acceptance)
//   s_axis_tdata   : signed input sample, channels arrive in order 0..NCH-1
//   s_axis_tvalid  : input valid
//   s_axis_tready  : input ready (only while idle)
//   m_axis_tdata   : signed output sample
//   m_axis_tuser   : channel index of the output beat
//   m_axis_tlast   : last beat of every LAST-th output frame
//   m_axis_tvalid  : output valid
//   m_axis_tready  : output ready
// -----------------------------------------------------------------------------
module str_mc_hb_deci #(
  parameter int unsigned DW         = 24,
  parameter int unsigned NCH        = 2,
  parameter int unsigned NTAP       = 11,
  parameter int unsigned COEF_W     = 18,
  parameter int unsigned NP         = (NTAP + 1) / 4,
  parameter int          HCOEF [NP] = '{37579, -5132, 319},
  parameter int unsigned LAST       = 16000
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     deci_en,
  input  logic signed [DW-1:0]                     s_axis_tdata,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  output logic signed [DW-1:0]                     m_axis_tdata,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] m_axis_tuser,
  output logic                                     m_axis_tlast,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready
);

  localparam int unsigned UW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int          C  = (int'(NTAP) - 1) / 2;
  localparam int unsigned AW = DW + COEF_W + $clog2(NTAP);
  // Product width: (DW+1)-bit pre-add times COEF_W-bit coefficient.
  localparam int unsigned PW = DW + 1 + COEF_W;
  localparam int unsigned SW = $clog2(NP + 2);
  localparam int unsigned FW = (LAST > 1) ? $clog2(LAST) : 1;

  // Round-half-up constant: 0.5 LSB of the output, i.e. 2^(COEF_W-2).
  localparam logic signed [AW-1:0] RND =
    {{(AW - COEF_W + 1){1'b0}}, 1'b1, {(COEF_W - 2){1'b0}}};
  localparam logic signed [AW-1:0] SMAX = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_e;

  state_e               r_state;
  logic                 r_rdy;
  logic                 r_vld;
  logic                 r_last;
  logic signed [DW-1:0] r_tdata;
  logic [UW-1:0]        r_tuser;
  logic [UW-1:0]        r_ch_in;
  logic [UW-1:0]        r_ch;
  logic signed [DW-1:0] r_dl [NCH][NTAP];
  logic [NCH-1:0]       r_ph;
  logic                 r_byp;
  logic signed [DW-1:0] r_smp;
  logic [SW-1:0]        r_step;
  logic signed [AW-1:0] r_acc;
  logic [FW-1:0]        r_frm;

  logic signed [DW-1:0]     w_lo;
  logic signed [DW-1:0]     w_hi;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [DW:0]       w_pre;
  logic signed [PW-1:0]     w_pre_x;
  logic signed [PW-1:0]     w_coef_x;
  logic signed [PW-1:0]     w_prod;
  logic signed [AW-1:0]     w_term;
  logic signed [DW-1:0]     w_cdl;
  logic signed [AW-1:0]     w_ctr;
  logic signed [AW-1:0]     w_rnd;
  logic signed [DW-1:0]     w_sat;
  logic                     w_last_nxt;

  // Step i (1..NP) of the MAC works on the tap pair C-(2i-1) / C+(2i-1).
  always_comb begin
    w_lo   = '0;
    w_hi   = '0;
    w_coef = '0;
    for (int j = 0; j < int'(NP); j++) begin
      if (r_step == SW'(j + 1)) begin
        w_lo   = r_dl[r_ch][C - 2 * j - 1];
        w_hi   = r_dl[r_ch][C + 2 * j + 1];
        w_coef = COEF_W'(HCOEF[j]);
      end
    end
  end

  // Symmetric taps share one coefficient: pre-add at DW+1 bits, then multiply.
  assign w_pre    = {w_lo[DW-1], w_lo} + {w_hi[DW-1], w_hi};
  assign w_pre_x  = {{(PW - DW - 1){w_pre[DW]}}, w_pre};
  assign w_coef_x = {{(PW - COEF_W){w_coef[COEF_W-1]}}, w_coef};
  assign w_prod   = w_pre_x * w_coef_x;
  assign w_term   = {{(AW - PW){w_prod[PW-1]}}, w_prod};

  // Centre tap is exactly 0.5, so it is a shift rather than a multiply.
  assign w_cdl = r_dl[r_ch][C];
  assign w_ctr = {{(AW - DW){w_cdl[DW-1]}}, w_cdl} << (COEF_W - 2);

  assign w_rnd = (r_acc + RND) >>> (COEF_W - 1);

  always_comb begin
    if (w_rnd > SMAX) begin
      w_sat = SMAX[DW-1:0];
    end else if (w_rnd < SMIN) begin
      w_sat = SMIN[DW-1:0];
    end else begin
      w_sat = w_rnd[DW-1:0];
    end
  end

  // tlast is decided when the beat is loaded; the counter only moves on a
  // transfer, so it cannot change while the beat is held.
  assign w_last_nxt = (r_ch == UW'(NCH - 1)) && (r_frm == FW'(LAST - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_rdy   <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_tdata <= '0;
      r_tuser <= '0;
      r_ch_in <= '0;
      r_ch    <= '0;
      r_ph    <= '0;
      r_byp   <= 1'b0;
      r_smp   <= '0;
      r_step  <= '0;
      r_acc   <= '0;
      r_frm   <= '0;
      for (int c = 0; c < int'(NCH); c++) begin
        for (int k = 0; k < int'(NTAP); k++) begin
          r_dl[c][k] <= '0;
        end
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          r_rdy <= 1'b1;
          if (s_axis_tvalid && r_rdy) begin
            r_ch    <= r_ch_in;
            r_ch_in <= (r_ch_in == UW'(NCH - 1)) ? '0 : r_ch_in + UW'(1);
            r_step  <= '0;
            if (deci_en) begin
              for (int c = 0; c < int'(NCH); c++) begin
                if (r_ch_in == UW'(c)) begin
                  r_dl[c][0] <= s_axis_tdata;
                  for (int k = 1; k < int'(NTAP); k++) begin
                    r_dl[c][k] <= r_dl[c][k-1];
                  end
                end
              end
              r_ph[r_ch_in] <= ~r_ph[r_ch_in];
              r_byp         <= 1'b0;
              // Only the odd-phase sample of a channel produces an output.
              if (r_ph[r_ch_in]) begin
                r_state <= StAcc;
                r_rdy   <= 1'b0;
              end
            end else begin
              // Bypass leaves the delay lines alone and restarts decimation
              // phase on every channel.
              r_ph    <= '0;
              r_smp   <= s_axis_tdata;
              r_byp   <= 1'b1;
              r_state <= StAcc;
              r_rdy   <= 1'b0;
            end
          end
        end

        StAcc: begin
          if (r_byp) begin
            r_tdata <= r_smp;
            r_tuser <= r_ch;
            r_last  <= w_last_nxt;
            r_vld   <= 1'b1;
            r_state <= StOut;
          end else if (r_step == SW'(NP + 1)) begin
            r_tdata <= w_sat;
            r_tuser <= r_ch;
            r_last  <= w_last_nxt;
            r_vld   <= 1'b1;
            r_state <= StOut;
          end else begin
            if (r_step == '0) begin
              r_acc <= w_ctr;
            end else begin
              r_acc <= r_acc + w_term;
            end
            r_step <= r_step + SW'(1);
          end
        end

        StOut: begin
          if (m_axis_tready) begin
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= StIdle;
            if (r_tuser == UW'(NCH - 1)) begin
              r_frm <= (r_frm == FW'(LAST - 1)) ? '0 : r_frm + FW'(1);
            end
          end
        end

        default: begin
          r_state <= StIdle;
          r_rdy   <= 1'b0;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = r_rdy;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_last;
  assign m_axis_tvalid = r_vld;

endmodule

// File: tb/tb_str_mc_hb_deci.sv
// -----------------------------------------------------------------------------
// tb_str_mc_hb_deci
//   Bench for str_mc_hb_deci (NCH=2, LAST=3, default taps). A reference model
//   keeps every accepted sample per channel and evaluates the full 11-tap
//   half-band convolution with plain integer arithmetic, then rounds and
//   saturates. Directed runs compare against hand-computed sequences; a
//   randomized run compares every beat against the model.
// -----------------------------------------------------------------------------
module tb_str_mc_hb_deci;

  localparam int DW     = 24;
  localparam int NCH    = 2;
  localparam int NTAP   = 11;
  localparam int COEF_W = 18;
  localparam int NP     = 3;
  localparam int LAST   = 3;
  localparam int C      = 5;
  localparam int HC [NP] = '{37579, -5132, 319};
  localparam longint PMAX = 8388607;
  localparam longint NMIN = -8388608;
  localparam int HMAX   = 4096;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 deci_en = 1'b1;
  logic signed [DW-1:0] s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic signed [DW-1:0] m_axis_tdata;
  logic [0:0]           m_axis_tuser;
  logic                 m_axis_tlast;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b1;

  str_mc_hb_deci #(
    .NCH  (NCH),
    .LAST (LAST)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .deci_en       (deci_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d;
    int     u;
    bit     l;
  } exp_t;

  int     n_total = 0;
  int     n_bad   = 0;
  int     cyc     = 0;
  int     exp_edge = 0;
  int     rdy_pct = 100;
  int     stall_left = 0;
  int     n_last = 0;

  // Reference model state
  longint xs [NCH][HMAX];
  int     nx [NCH];
  bit     ph [NCH];
  int     ch_in = 0;
  int     frm = 0;
  exp_t   exp_q [$];

  longint cap0 [$];
  longint cap1 [$];

  bit     prev_vld = 1'b0;
  bit     prev_xfer = 1'b0;
  longint prev_data = 0;
  longint prev_user = 0;
  longint prev_last = 0;

  longint ea [12] = '{0, 0, 524288, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  longint eb [12] = '{2552, -41056, 300632, 300632, -41056, 2552, 0, 0, 0, 0, 0, 0};
  longint sp [12] = '{0, PMAX, 0, NMIN, 0, PMAX, PMAX, PMAX, 0, NMIN, 0, PMAX};

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint hcoef(input int k);
    int d;
    d = (k > C) ? (k - C) : (C - k);
    if (d == 0) return 65536;
    if ((d % 2) == 1) return longint'(HC[(d - 1) / 2]);
    return 0;
  endfunction

  // y[n] = sum_k h[k] * x[n-k], rounded half up to Q0, saturated to DW bits.
  function automatic longint ref_y(input int c);
    longint acc;
    longint y;
    int     idx;
    acc = 0;
    for (int k = 0; k < NTAP; k++) begin
      idx = nx[c] - 1 - k;
      if (idx >= 0) acc += hcoef(k) * xs[c][idx];
    end
    y = (acc + 65536) >>> 17;
    if (y > PMAX) y = PMAX;
    if (y < NMIN) y = NMIN;
    return y;
  endfunction

  task automatic push_exp(input longint y, input int c, input int lat);
    exp_t e;
    e.d = y;
    e.u = c;
    e.l = (c == NCH - 1) && (frm == LAST - 1);
    if (c == NCH - 1) frm = (frm + 1) % LAST;
    exp_q.push_back(e);
    exp_edge = cyc + 1 + lat;
  endtask

  task automatic model_accept(input longint d, input bit en);
    int c;
    c = ch_in;
    ch_in = (ch_in + 1) % NCH;
    if (en) begin
      xs[c][nx[c]] = d;
      nx[c]++;
      if (ph[c]) push_exp(ref_y(c), c, NP + 2);
      ph[c] = !ph[c];
    end else begin
      for (int i = 0; i < NCH; i++) ph[i] = 1'b0;
      push_exp(d, c, 1);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      nx[i] = 0;
      ph[i] = 1'b0;
    end
    ch_in = 0;
    frm = 0;
    exp_q.delete();
    prev_vld = 1'b0;
    prev_xfer = 1'b0;
  endtask

  // Called just after a falling edge with inputs already set: evaluates what
  // the next rising edge will do, then advances to the next falling edge.
  task automatic tick();
    bit   acc;
    bit   xfer;
    exp_t e;
    m_axis_tready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (stall_left > 0) stall_left--;
    if (rst_n) begin
      acc  = s_axis_tvalid && s_axis_tready;
      xfer = m_axis_tvalid && m_axis_tready;
      if (m_axis_tvalid) begin
        check_val("ready_while_out", longint'(s_axis_tready), 0);
        if (!prev_vld) begin
          check_val("latency_edge", cyc, exp_edge);
        end else if (!prev_xfer) begin
          check_val("hold_data", m_axis_tdata, prev_data);
          check_val("hold_user", longint'(m_axis_tuser), prev_user);
          check_val("hold_last", longint'(m_axis_tlast), prev_last);
        end
        if (xfer) begin
          check_val("beat_expected", longint'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("out_data", m_axis_tdata, e.d);
            check_val("out_user", longint'(m_axis_tuser), e.u);
            check_val("out_last", longint'(m_axis_tlast), longint'(e.l));
          end
          if (m_axis_tuser == 1'b0) cap0.push_back(m_axis_tdata);
          else cap1.push_back(m_axis_tdata);
          if (m_axis_tlast) n_last++;
        end
      end
      prev_vld  = m_axis_tvalid;
      prev_xfer = xfer;
      prev_data = m_axis_tdata;
      prev_user = longint'(m_axis_tuser);
      prev_last = longint'(m_axis_tlast);
      if (acc) model_accept(s_axis_tdata, deci_en);
    end else begin
      prev_vld = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    stall_left = 0;
    tick();
    check_val("rst_tvalid", longint'(m_axis_tvalid), 0);
    check_val("rst_tready", longint'(s_axis_tready), 0);
    check_val("rst_tdata", m_axis_tdata, 0);
    check_val("rst_tuser", longint'(m_axis_tuser), 0);
    check_val("rst_tlast", longint'(m_axis_tlast), 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    check_val("rdy_after_rst", longint'(s_axis_tready), 1);
    cap0.delete();
    cap1.delete();
    n_last = 0;
  endtask

  // deci_en is scrambled while the DUT is busy; only its value at acceptance
  // may matter.
  task automatic push_beat(input longint d, input bit en);
    int n;
    bit got;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(d);
    while (1) begin
      deci_en = s_axis_tready ? en : 1'($urandom);
      got = s_axis_tready;
      tick();
      if (got) break;
      n++;
      if (n > 60) begin
        check_val("push_timeout", n, 0);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_axis_tvalid = 1'b0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 200) begin
      tick();
      n++;
    end
    check_val("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint d;
    @(negedge clk);
    do_reset();

    // Centre tap only: impulse on the even phase of ch0.
    for (int i = 0; i < 24; i++) begin
      push_beat((i == 0) ? 1048576 : 0, 1'b1);
      push_beat(0, 1'b1);
    end
    drain();
    check_val("ctr_count", cap0.size(), 12);
    for (int i = 0; i < 12 && i < cap0.size(); i++) check_val("ctr_seq", cap0[i], ea[i]);

    // Odd taps on ch0, unity-ish gain on constant ch1.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      push_beat((i == 1) ? 1048576 : 0, 1'b1);
      push_beat(1000, 1'b1);
    end
    drain();
    check_val("odd_count", cap0.size(), 12);
    for (int i = 0; i < 12 && i < cap0.size(); i++) check_val("odd_seq", cap0[i], eb[i]);
    for (int i = 5; i < cap1.size(); i++) check_val("dc_settle", cap1[i], 1000);

    // Saturation both ways.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      d = (i < 12) ? sp[i] : ((sp[i-12] == PMAX) ? NMIN : ((sp[i-12] == NMIN) ? PMAX : 0));
      push_beat(d, 1'b1);
      push_beat(0, 1'b1);
    end
    drain();
    if (cap0.size() == 12) begin
      check_val("sat_pos", cap0[5], PMAX);
      check_val("sat_neg", cap0[11], NMIN);
    end else begin
      check_val("sat_count", cap0.size(), 12);
    end

    // Bypass.
    do_reset();
    push_beat(5, 1'b0);
    push_beat(-7, 1'b0);
    push_beat(9, 1'b0);
    drain();
    check_val("byp_n0", cap0.size(), 2);
    check_val("byp_n1", cap1.size(), 1);
    if (cap0.size() == 2 && cap1.size() == 1) begin
      check_val("byp_a", cap0[0], 5);
      check_val("byp_b", cap1[0], -7);
      check_val("byp_c", cap0[1], 9);
    end

    // Back-pressure stall and tlast every 3rd ch1 beat.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 4) stall_left = 10;
      push_beat(longint'($urandom_range(200000)) - 100000, 1'b1);
      push_beat(longint'($urandom_range(200000)) - 100000, 1'b1);
    end
    drain();
    check_val("last_count", n_last, 2);

    // Reset in the middle of an accumulation, then a fresh impulse run.
    do_reset();
    push_beat(123456, 1'b1);
    push_beat(0, 1'b1);
    push_beat(-654321, 1'b1);
    tick();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      push_beat((i == 1) ? 1048576 : 0, 1'b1);
      push_beat(1000, 1'b1);
    end
    drain();
    check_val("rst_odd_count", cap0.size(), 12);
    for (int i = 0; i < 12 && i < cap0.size(); i++) check_val("rst_odd_seq", cap0[i], eb[i]);

    // Randomized traffic against the model.
    do_reset();
    rdy_pct = 70;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(9))
        0:       d = PMAX;
        1:       d = NMIN;
        2, 3, 4: d = longint'($urandom_range(16777215)) - 8388608;
        default: d = longint'($urandom_range(4000)) - 2000;
      endcase
      if (i == 300) stall_left = 10;
      push_beat(d, ($urandom_range(9) != 0));
      if ($urandom_range(7) == 0) tick();
    end
    drain();
    rdy_pct = 100;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/str_mc_hb_deci.md
Name: str_mc_hb_deci

Overview:
- Multi-channel, time-multiplexed half-band FIR decimate-by-2 stage for the LPDAQ down-sample chain.
- Replaces one fir+deci pair per channel with a single folded-symmetric sequential MAC over NCH channel-interleaved streams.
- Adds runtime bypass, a channel-index sideband and a frame-based tlast.
- Sits between the CIC and the final equiripple FIR; stages can be cascaded.

Parameters:
- DW, 24: sample width, signed.
- NCH, 2: number of interleaved channels (>=1).
- NTAP, 11: half-band length; must be 4k+3; centre index C=(NTAP-1)/2.
- COEF_W, 18: coefficient width, signed Q1.(COEF_W-1); centre tap is fixed at 2^(COEF_W-2) (0.5).
- NP, (NTAP+1)/4: number of non-zero off-centre tap pairs (derived).
- HCOEF, '{37579,-5132,319}: NP integers for h[C±1], h[C±3], h[C±5], ... ordered innermost first.
- LAST, 16000: output frames per m_axis_tlast.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset; synchronous, active-low.
- deci_en, input, 1: 1 = filter and decimate; 0 = bypass.
- s_axis_tdata, input, DW: signed input sample; channels arrive in fixed order ch0..chNCH-1.
- s_axis_tvalid, input, 1: input valid.
- s_axis_tready, output, 1: input ready.
- m_axis_tdata, output, DW: signed output sample.
- m_axis_tuser, output, max(1,$clog2(NCH)): channel index of the output beat.
- m_axis_tlast, output, 1: last beat of every LAST-th output frame.
- m_axis_tvalid, output, 1: output valid.
- m_axis_tready, input, 1: output ready.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; s_axis_tready=0 during reset, 1 on the first cycle after; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0; all delay lines=0; all phase bits=0; ch_in=0; frame counter=0. Reset mid-operation abandons any MAC or pending output with no partial beat.
- FSM IDLE -> ACC -> OUT -> IDLE. s_axis_tready=1 only in IDLE; m_axis_tvalid=1 only in OUT.
- IDLE, beat accepted on channel ch=ch_in:
  - ch_in increments and wraps at NCH-1 to 0.
  - deci_en=1: shift the sample into dl[ch][0] (dl[ch][k] <= dl[ch][k-1]), then toggle ph[ch].
  - If ph[ch] was 0 (even sample): no output, stay IDLE.
  - If ph[ch] was 1: go ACC.
  - deci_en=0: do not touch the delay line; clear all ph to 0; latch the sample; go OUT with tdata=sample, tuser=ch.
- ACC, NP+1 cycles:
  - Cycle 0: acc = dl[C] << (COEF_W-2).
  - Cycle i (1..NP): acc += HCOEF[i-1]*(dl[C-(2i-1)] + dl[C+(2i-1)]), with the pre-add at DW+1 bits.
  - Accumulator width is DW+COEF_W+$clog2(NTAP).
  - After the last cycle: y = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), i.e. round half up, then saturate to [-2^(DW-1), 2^(DW-1)-1]. Register y into m_axis_tdata with tuser=ch and go OUT.
- Latency: accept at edge t -> m_axis_tvalid high after edge t+NP+2 in decimate mode, or after edge t+1 in bypass.
- OUT: hold tdata/tuser/tlast stable until m_axis_tvalid&&m_axis_tready, then go IDLE the next cycle with m_axis_tvalid=0. No input is accepted while in ACC or OUT.
- tlast:
  - The frame counter increments on each transfer with tuser=NCH-1 and wraps at LAST-1.
  - m_axis_tlast=1 on the tuser=NCH-1 beat when the counter equals LAST-1.
  - Bypass and decimate outputs both count.
- deci_en is sampled only at IDLE acceptance. Toggling it mid-ACC or in OUT has no effect on the current sample.
- Symmetric-tap sums use pre-add then multiply. The even off-centre taps are exactly 0 and are never computed.

Test Plan:
- Centre-tap path (NCH=1, defaults, deci_en=1): feed 2^20 as sample 1, then 23 zeros -> 12 outputs 0,0,524288,0,0,0,0,... (only the centre tap contributes).
- Odd-tap path: feed 0, then 2^20, then 22 zeros -> outputs 2552,-41056,300632,300632,-41056,2552, then 0s.
- Saturation (HCOEF='{40000,0,0}): constant 8388607 -> settled output 8388607; constant -8388608 -> settled output -8388608; no wrap.
- Multi-channel (NCH=2): ch0 = impulse on odd phase, ch1 = constant 1000 -> tuser alternates 0,1; ch0 shows the odd-path sequence; ch1 settles to 1000 (gain 131068/131072 rounds to 1000); no cross-channel leakage.
- Handshake and last (LAST=3, NCH=2): hold m_axis_tready=0 for 10 cycles mid-stream -> tdata/tuser stable and s_axis_tready=0 throughout; tlast only on the 3rd, 6th, ... ch1 beats.
- Bypass and reset: with deci_en=0, input 5,-7,9 -> outputs 5,-7,9, each one cycle after acceptance. Assert rst_n=0 during ACC -> next cycle tvalid=0 and tready=0; after release, the first filtered output matches a fresh-reset run.
